ram_burst_ctrl: RTL and testbench

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

---
 rtl/ram_burst_ctrl_if.sv | 29 ++
 rtl/ram_burst_ctrl.sv | 99 +++++++++
 tb/tb_ram_burst_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_burst_ctrl_if.sv
// Bus bundle for the burst controller: command channel, write-data stream,
// RAM port and status outputs.
interface ram_burst_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [6:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [7:0]  ram_data;
    logic [6:0]  ram_addr;
    logic        ram_en;
    logic [7:0]  ram_q;
    logic        busy;
    logic        done;
    logic [15:0] sum;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, in_valid, in_data, ram_q,
        input  cmd_ready, in_ready, ram_data, ram_addr, ram_en, busy, done, sum
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, in_valid, in_data, ram_q,
        output cmd_ready, in_ready, ram_data, ram_addr, ram_en, busy, done, sum
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst controller for a 128 x 8 RAM: streams write bursts into the RAM and
// sums the bytes of read bursts, with 7-bit wrapping addresses.
module ram_burst_ctrl (
    input logic             clk,
    input logic             reset,
    ram_burst_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [6:0]  cur_addr;
    logic [7:0]  remaining;
    logic [15:0] sum_q;
    logic        accept;
    logic        step;

    assign accept = bus.cmd_valid && (state == IDLE);
    assign step   = ((state == WRITE) && bus.in_valid) || (state == READ);

    assign bus.ram_addr = cur_addr;
    assign bus.sum      = sum_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A burst ends on the transfer that takes remaining from 1 to 0; an empty
    // burst jumps straight to DONE so it still produces a done pulse.
    always_comb begin
        state_next    = state;
        bus.cmd_ready = 1'b0;
        bus.in_ready  = 1'b0;
        bus.ram_en    = 1'b0;
        bus.ram_data  = 8'd0;
        bus.busy      = 1'b1;
        bus.done      = 1'b0;
        unique case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == 8'd0) begin
                        state_next = DONE;
                    end else if (bus.cmd_write) begin
                        state_next = WRITE;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            WRITE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    bus.ram_en   = 1'b1;
                    bus.ram_data = bus.in_data;
                    if (remaining == 8'd1) begin
                        state_next = DONE;
                    end
                end
            end
            READ: begin
                if (remaining == 8'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.done   = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Sum is cleared only when a read command is accepted, so write bursts
    // leave the previous read result visible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_addr  <= 7'd0;
            remaining <= 8'd0;
            sum_q     <= 16'd0;
        end else if (accept) begin
            cur_addr  <= bus.cmd_addr;
            remaining <= bus.cmd_len;
            if (!bus.cmd_write) begin
                sum_q <= 16'd0;
            end
        end else if (step) begin
            cur_addr  <= cur_addr + 7'd1;
            remaining <= remaining - 8'd1;
            if (state == READ) begin
                sum_q <= sum_q + {8'd0, bus.ram_q};
            end
        end
    end
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl: a behavioural RAM image predicts every
// RAM write and every burst result; a negedge monitor compares them.
module tb_ram_burst_ctrl;
    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] sum;
        bit          isRead;
        int          readCycles;
    } done_t;

    logic clk;
    logic rst_n;
    ram_burst_ctrl_if bus ();

    logic [7:0]  ramMem   [128];
    logic [7:0]  modelMem [128];
    logic [7:0]  wrData   [256];
    logic [15:0] modelSum;
    wr_t         wq [$];
    done_t       dq [$];
    int          checks;
    int          errors;
    int          doneCount;
    int          busyRun;
    bit          prevDone;

    ram_burst_ctrl dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The RAM itself: combinational read, write on the rising edge.
    assign bus.ram_q = ramMem[bus.ram_addr];
    always @(posedge clk) begin
        if (bus.ram_en) ramMem[bus.ram_addr] <= bus.ram_data;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            busyRun  = 0;
            prevDone = 1'b0;
        end else begin
            if (bus.ram_en) begin
                if (wq.size() == 0) begin
                    checkOutput("unexpected_write", 32'(bus.ram_addr), 32'hFFFF_FFFF);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    checkOutput("write_addr", 32'(bus.ram_addr), 32'(w.addr));
                    checkOutput("write_data", 32'(bus.ram_data), 32'(w.data));
                end
            end else begin
                checkOutput("ram_data_idle", 32'(bus.ram_data), 32'd0);
            end
            if (bus.busy && !bus.done) busyRun++;
            if (bus.done) begin
                checkOutput("done_width", 32'(prevDone), 32'd0);
                if (dq.size() == 0) begin
                    checkOutput("unexpected_done", 32'd1, 32'd0);
                end else begin
                    done_t d;
                    d = dq.pop_front();
                    checkOutput("burst_sum", 32'(bus.sum), 32'(d.sum));
                    if (d.isRead) checkOutput("read_cycles", busyRun, d.readCycles);
                end
                busyRun = 0;
                doneCount++;
            end
            prevDone = bus.done;
        end
    end

    // Issues one burst and predicts it; abortAt >= 0 asserts reset while the
    // byte with that index is offered, so only earlier bytes are expected.
    task automatic applyStimulus(input bit wr, input logic [6:0] addr, input logic [7:0] len,
                                 input int gapMode, input bit intrude, input int abortAt);
        int          nWrites;
        int          startDone;
        int          n;
        wr_t         w;
        done_t       d;
        logic [15:0] s;
        nWrites = (abortAt >= 0) ? abortAt : int'(len);
        if (wr) begin
            for (int i = 0; i < nWrites; i++) begin
                w.addr = 7'((int'(addr) + i) % 128);
                w.data = wrData[i];
                wq.push_back(w);
                modelMem[w.addr] = w.data;
            end
        end else begin
            s = 16'd0;
            for (int i = 0; i < int'(len); i++) s = s + 16'(modelMem[(int'(addr) + i) % 128]);
            modelSum = s;
        end
        if (abortAt < 0) begin
            d.sum        = modelSum;
            d.isRead     = !wr;
            d.readCycles = int'(len);
            dq.push_back(d);
        end
        startDone     = doneCount;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (intrude) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_write = 1'b1;
            bus.cmd_addr  = 7'($urandom);
            bus.cmd_len   = 8'd5;
            repeat (3) begin
                @(posedge clk); #1;
            end
            bus.cmd_valid = 1'b0;
        end
        if (wr) begin
            for (int i = 0; i < int'(len); i++) begin
                if ((gapMode == 1 && i > 0) || (gapMode == 2 && $urandom_range(0, 2) == 0)) begin
                    bus.in_valid = 1'b0;
                    @(posedge clk); #1;
                end
                bus.in_data  = wrData[i];
                bus.in_valid = 1'b1;
                if (i == abortAt) begin
                    #2 rst_n = 1'b0;
                    #1 checkOutput("abort_ram_en", 32'(bus.ram_en), 32'd0);
                    break;
                end
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b0;
            bus.in_data  = 8'd0;
        end
        if (abortAt < 0) begin
            n = 0;
            while (doneCount == startDone && n < 700) begin
                @(posedge clk); #1;
                n++;
            end
            checkOutput("done_seen", 32'(doneCount != startDone), 32'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks   = 0;
        errors   = 0;
        doneCount = 0;
        busyRun  = 0;
        prevDone = 1'b0;
        modelSum = 16'd0;
        for (int i = 0; i < 128; i++) begin
            ramMem[i]   = 8'd0;
            modelMem[i] = 8'd0;
        end
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 7'd0;
        bus.cmd_len   = 8'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy",      32'(bus.busy),      32'd0);
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rst_in_ready",  32'(bus.in_ready),  32'd0);
        checkOutput("rst_ram_en",    32'(bus.ram_en),    32'd0);
        checkOutput("rst_ram_addr",  32'(bus.ram_addr),  32'd0);
        checkOutput("rst_ram_data",  32'(bus.ram_data),  32'd0);
        checkOutput("rst_done",      32'(bus.done),      32'd0);
        checkOutput("rst_sum",       32'(bus.sum),       32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        wrData[0] = 8'h12;
        wrData[1] = 8'h34;
        applyStimulus(1'b1, 7'd33, 8'd2, 0, 1'b0, -1);
        checkOutput("ram33", 32'(ramMem[33]), 32'h12);
        checkOutput("ram34", 32'(ramMem[34]), 32'h34);
        applyStimulus(1'b0, 7'd33, 8'd2, 0, 1'b0, -1);
        checkOutput("sum_33_34", 32'(bus.sum), 32'h0046);

        for (int i = 0; i < 4; i++) wrData[i] = 8'hFF;
        applyStimulus(1'b1, 7'd126, 8'd4, 1, 1'b0, -1);
        checkOutput("ram126", 32'(ramMem[126]), 32'hFF);
        checkOutput("ram127", 32'(ramMem[127]), 32'hFF);
        checkOutput("ram0",   32'(ramMem[0]),   32'hFF);
        checkOutput("ram1",   32'(ramMem[1]),   32'hFF);
        applyStimulus(1'b0, 7'd126, 8'd4, 0, 1'b0, -1);
        checkOutput("sum_wrap", 32'(bus.sum), 32'h03FC);

        applyStimulus(1'b1, 7'd50, 8'd0, 0, 1'b0, -1);
        applyStimulus(1'b0, 7'd10, 8'd0, 0, 1'b0, -1);
        checkOutput("sum_len0", 32'(bus.sum), 32'h0000);

        for (int i = 0; i < 128; i++) wrData[i] = 8'hFF;
        applyStimulus(1'b1, 7'd0, 8'd128, 0, 1'b0, -1);
        applyStimulus(1'b0, 7'd0, 8'd255, 0, 1'b0, -1);
        checkOutput("sum_max", 32'(bus.sum), 32'hFE01);

        for (int k = 0; k < 30; k++) begin
            bit         wr;
            logic [6:0] addr;
            logic [7:0] len;
            wr   = 1'($urandom_range(0, 1));
            addr = 7'($urandom);
            len  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 20));
            for (int i = 0; i < 256; i++) wrData[i] = 8'($urandom);
            applyStimulus(wr, addr, len, int'($urandom_range(0, 2)),
                          (!wr && len >= 8'd5) ? 1'($urandom_range(0, 1)) : 1'b0, -1);
        end

        applyStimulus(1'b0, 7'd120, 8'd10, 0, 1'b1, -1);

        for (int i = 0; i < 10; i++) wrData[i] = 8'($urandom_range(1, 254));
        applyStimulus(1'b1, 7'd90, 8'd10, 0, 1'b0, 2);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort_busy",      32'(bus.busy),      32'd0);
        checkOutput("abort_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("abort_in_ready",  32'(bus.in_ready),  32'd0);
        checkOutput("abort_sum",       32'(bus.sum),       32'd0);
        modelSum = 16'd0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_busy",      32'(bus.busy),      32'd0);
        checkOutput("post_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("kept_ram90", 32'(ramMem[90]), 32'(wrData[0]));
        checkOutput("kept_ram91", 32'(ramMem[91]), 32'(wrData[1]));
        checkOutput("kept_ram92", 32'(ramMem[92]), 32'(modelMem[92]));
        applyStimulus(1'b0, 7'd90, 8'd3, 0, 1'b0, -1);

        checkOutput("queues_drained", 32'(wq.size() + dq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
